ex_mdu_unit: RTL and testbench
==============================

EX_MDU_UNIT -- requirements
Module: ex_mdu_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, $clog2(XLEN), shift-amount width (derived; not overridden).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 SHALL have port in_valid  input  1  operation request.
REQ-007 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-008 SHALL have port op  input  5  operation code (REQ-013).
REQ-009 SHALL have ports rd1, rd2, immExt  input  XLEN  operands; aluSrc  input  1  selects immExt as B for ops 0-4 and 11-13.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports aluResult  output  XLEN, zero  output  1 (aluResult==0), illegal  output  1 (unsupported op).

Function
REQ-013 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQ, 6 NE, 7 LT, 8 GE, 9 LTU, 10 GEU, 11 SLL, 12 SRL, 13 SRA, 16 MUL, 17 MULH, 18 MULHU, 19 DIV, 20 DIVU, 21 REM, 22 REMU; all others illegal.
REQ-014 Compare ops 5-10 SHALL use rd1/rd2 only (ignore aluSrc), result 1 or 0 zero-extended.
REQ-015 Shifts SHALL use B[SHW-1:0] as amount.
REQ-016 States SHALL be IDLE, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-017 Handshake accept = in_valid & in_ready; operands and op SHALL be captured at accept.
REQ-018 Ops 0-13 and illegal ops: IDLE -> DONE, out_valid asserted the cycle after accept (latency 1); illegal ops give aluResult 0, illegal 1.
REQ-019 MUL ops: IDLE -> MUL, radix-2 shift-add over exactly XLEN cycles, then DONE; out_valid at accept+XLEN+1.
REQ-020 MUL returns low XLEN bits; MULH signed x signed high XLEN; MULHU unsigned high XLEN.
REQ-021 DIV ops: IDLE -> DIV, restoring division on magnitudes over exactly XLEN cycles, sign fix-up in last cycle; out_valid at accept+XLEN+1.
REQ-022 Divide by zero SHALL give quotient all ones, remainder = rd1, with no trap.
REQ-023 Signed overflow (rd1 = most-negative, rd2 = -1) SHALL give DIV quotient = rd1, REM = 0.
REQ-024 DONE: aluResult/zero/illegal SHALL hold stable while out_valid & !out_ready; DONE -> IDLE on out_ready.
REQ-025 A new request SHALL NOT be accepted in the same cycle a result is consumed (in_ready rises the cycle after).
REQ-026 flush SHALL force state IDLE and out_valid 0 next cycle from any state, discarding result; flush has priority over accept and out_ready.
REQ-027 Arithmetic SHALL wrap modulo 2^XLEN; no overflow flags.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, aluResult 0, zero 1, illegal 0, iteration counter 0.
REQ-029 Reset mid-MUL/DIV SHALL discard the operation; first accept is possible the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro EX_MDU_DIV_EN: defined -> ops 19-22 per REQ-021..023; undefined -> no divider logic, ops 19-22 treated as illegal (REQ-018, latency 1).

Verification
REQ-031 ADD rd1=5, immExt=7, aluSrc=1 -> out_valid next cycle, aluResult 12, zero 0.
REQ-032 MULH rd1=0xFFFFFFFF, rd2=0x00000002 (XLEN=32) -> out_valid at accept+33, aluResult 0xFFFFFFFF; MUL same -> 0xFFFFFFFE.
REQ-033 DIV rd1=0x80000000, rd2=0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU rd1=7, rd2=0 -> 0xFFFFFFFF; REMU -> 7.
REQ-034 DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; without EX_MDU_DIV_EN same op -> illegal 1, aluResult 0, latency 1.
REQ-035 out_ready held 0 for 5 cycles after SUB 3-3 -> aluResult 0, zero 1 stable, in_ready 0 throughout; release -> in_ready 1 following cycle.
REQ-036 flush at MUL cycle 10, and separately rst_n low at DIV cycle 5 -> no out_valid, in_ready 1 next cycle, subsequent ADD 1+1 -> 2.

Source files
------------

// File: rtl/ex_mdu_unit.sv
// Execute-stage ALU with iterative multiplier and optional restoring divider.
// Divider is built only when EX_MDU_DIV_EN is defined; otherwise ops 19-22 decode as illegal.
module ex_mdu_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] immExt,
  input  logic            aluSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluResult,
  output logic            zero,
  output logic            illegal
);

  localparam logic [4:0] OpAdd = 5'd0,  OpSub = 5'd1,  OpAnd = 5'd2,  OpOr = 5'd3,  OpXor = 5'd4;
  localparam logic [4:0] OpEq  = 5'd5,  OpNe  = 5'd6,  OpLt  = 5'd7,  OpGe = 5'd8;
  localparam logic [4:0] OpLtu = 5'd9,  OpGeu = 5'd10, OpSll = 5'd11, OpSrl = 5'd12, OpSra = 5'd13;
  localparam logic [4:0] OpMul = 5'd16, OpMulh = 5'd17, OpMulhu = 5'd18;
  localparam logic [4:0] OpDiv = 5'd19, OpDivu = 5'd20, OpRem = 5'd21, OpRemu = 5'd22;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q;
  logic [4:0]      op_q;
  logic            neg_q;

  logic [XLEN-1:0] opb_sel, alu_res, a_mag, b_mag;
  logic [SHW-1:0]  shamt;
  logic            alu_ill, is_mul, is_div, sgn_op;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign opb_sel   = aluSrc ? immExt : rd2;
  assign shamt     = opb_sel[SHW-1:0];

  // Signed multiply/divide iterate on magnitudes; the sign is restored on the last step.
  assign sgn_op = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  assign a_mag  = (sgn_op && rd1[XLEN-1]) ? -rd1 : rd1;
  assign b_mag  = (sgn_op && rd2[XLEN-1]) ? -rd2 : rd2;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (op)
      OpAdd:   alu_res = rd1 + opb_sel;
      OpSub:   alu_res = rd1 - opb_sel;
      OpAnd:   alu_res = rd1 & opb_sel;
      OpOr:    alu_res = rd1 | opb_sel;
      OpXor:   alu_res = rd1 ^ opb_sel;
      OpEq:    alu_res = {{(XLEN-1){1'b0}}, rd1 == rd2};
      OpNe:    alu_res = {{(XLEN-1){1'b0}}, rd1 != rd2};
      OpLt:    alu_res = {{(XLEN-1){1'b0}}, $signed(rd1) < $signed(rd2)};
      OpGe:    alu_res = {{(XLEN-1){1'b0}}, $signed(rd1) >= $signed(rd2)};
      OpLtu:   alu_res = {{(XLEN-1){1'b0}}, rd1 < rd2};
      OpGeu:   alu_res = {{(XLEN-1){1'b0}}, rd1 >= rd2};
      OpSll:   alu_res = rd1 << shamt;
      OpSrl:   alu_res = rd1 >> shamt;
      OpSra:   alu_res = XLEN'($signed(rd1) >>> shamt);
      OpMul, OpMulh, OpMulhu: is_mul = 1'b1;
`ifdef EX_MDU_DIV_EN
      OpDiv, OpDivu, OpRem, OpRemu: is_div = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Shift-add step: hi accumulates the multiplicand, {hi,lo} shifts right one bit per cycle.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod, mul_fin;
  logic [XLEN-1:0]   mul_res;
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_prod = {mul_sum, lo_q[XLEN-1:1]};
  assign mul_fin  = neg_q ? -mul_prod : mul_prod;
  assign mul_res  = (op_q == OpMul) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

`ifdef EX_MDU_DIV_EN
  // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic            neg_rem_q, q_bit;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;
  assign rem_sh  = {hi_q, lo_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, opb_q};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt = {lo_q[XLEN-2:0], q_bit};
  assign div_res = ((op_q == OpDiv) || (op_q == OpDivu)) ? (neg_q ? -quo_nxt : quo_nxt)
                                                         : (neg_rem_q ? -rem_nxt : rem_nxt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      aluResult <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
`ifdef EX_MDU_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: if (in_valid) begin
          op_q  <= op;
          hi_q  <= '0;
          lo_q  <= a_mag;
          opb_q <= b_mag;
          cnt_q <= '0;
          // Divide-by-zero keeps the all-ones quotient unsigned-looking.
          neg_q <= sgn_op && (rd1[XLEN-1] ^ rd2[XLEN-1]) && (rd2 != '0);
`ifdef EX_MDU_DIV_EN
          neg_rem_q <= sgn_op && rd1[XLEN-1];
`endif
          if (is_mul) begin
            state_q <= StMul;
          end else if (is_div) begin
            state_q <= StDiv;
          end else begin
            aluResult <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= alu_ill;
            state_q   <= StDone;
          end
        end
        StMul: begin
          hi_q  <= mul_sum[XLEN:1];
          lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            aluResult <= mul_res;
            zero      <= (mul_res == '0);
            illegal   <= 1'b0;
            state_q   <= StDone;
          end
        end
`ifdef EX_MDU_DIV_EN
        StDiv: begin
          hi_q  <= rem_nxt;
          lo_q  <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN-1)) begin
            aluResult <= div_res;
            zero      <= (div_res == '0);
            illegal   <= 1'b0;
            state_q   <= StDone;
          end
        end
`endif
        StDone: if (out_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_unit.sv
// Scoreboard bench for ex_mdu_unit: driver pushes expected results, monitor pops on handshake.
module tb_ex_mdu_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] rd1 = '0, rd2 = '0, immExt = '0;
  logic        aluSrc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] aluResult;
  logic        zero, illegal;

  ex_mdu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd1(rd1), .rd2(rd2), .immExt(immExt), .aluSrc(aluSrc),
    .out_valid(out_valid), .out_ready(out_ready), .aluResult(aluResult), .zero(zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: latency is measured to the first cycle out_valid is seen.
  bit   seen = 0;
  int   first_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {32'd0, aluResult}, {32'd0, e.res});
          chk("zero", {63'd0, zero}, {63'd0, (e.res == 32'd0)});
          chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
          chk("latency", 64'(first_cyc - e.acc), 64'(e.lat));
        end
        seen = 0;
      end
    end
  end

  task automatic send(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic src, output int acc);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    op = o; rd1 = a; rd2 = b; immExt = imm; aluSrc = src;
    in_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src,
                       input logic [31:0] res, input logic ill, input int lat);
    int acc;
    exp_t x;
    send(o, a, b, imm, src, acc);
    x.res = res; x.ill = ill; x.acc = acc; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #12;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", {32'd0, aluResult}, 64'd0);
    chk("reset_zero", {63'd0, zero}, 64'd1);
    chk("reset_illegal", {63'd0, illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU ops, latency 1
    issue(5'd0, 32'd5, 32'd100, 32'd7, 1'b1, 32'd12, 1'b0, 1);
    issue(5'd1, 32'd10, 32'd3, 32'd0, 1'b0, 32'd7, 1'b0, 1);
    issue(5'd4, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_0000, 1'b1, 32'h0F0F_F0F0, 1'b0, 1);
    issue(5'd5, 32'd5, 32'd5, 32'd9, 1'b1, 32'd1, 1'b0, 1);
    issue(5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1);
    issue(5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0, 1);
    issue(5'd11, 32'd3, 32'd0, 32'd33, 1'b1, 32'd6, 1'b0, 1);
    issue(5'd13, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 32'hF800_0000, 1'b0, 1);
    issue(5'd14, 32'd1, 32'd2, 32'd3, 1'b0, 32'd0, 1'b1, 1);
    drain();

    // Multiplier, latency XLEN+1
    issue(5'd17, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    issue(5'd16, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'hFFFF_FFFE, 1'b0, 33);
    issue(5'd18, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'd1, 1'b0, 33);
    issue(5'd17, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, 32'h3FFF_FFFF, 1'b0, 33);
    drain();

`ifdef EX_MDU_DIV_EN
    issue(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h8000_0000, 1'b0, 33);
    issue(5'd21, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 1'b0, 33);
    issue(5'd20, 32'd7, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    issue(5'd22, 32'd7, 32'd0, 32'd0, 1'b0, 32'd7, 1'b0, 33);
    issue(5'd19, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'hFFFF_FFFD, 1'b0, 33);
    issue(5'd21, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 33);
    issue(5'd20, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14, 1'b0, 33);
`else
    issue(5'd19, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'd0, 1'b1, 1);
    issue(5'd22, 32'd7, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1);
`endif
    drain();

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(5'd1, 32'd3, 32'd3, 32'd0, 1'b0, 32'd0, 1'b0, 1);
    begin
      int w = 0;
      while (!out_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_result", {32'd0, aluResult}, 64'd0);
      chk("stall_zero", {63'd0, zero}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("consume_cycle_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("after_consume_in_ready", {63'd0, in_ready}, 64'd1);
    chk("after_consume_out_valid", {63'd0, out_valid}, 64'd0);
    drain();

    // Flush in the middle of a multiply
    send(5'd16, 32'd12345, 32'd678, 32'd0, 1'b0, acc);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    issue(5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 1'b0, 1);
    drain();

    // Asynchronous reset in the middle of a long operation
`ifdef EX_MDU_DIV_EN
    send(5'd19, 32'd1000, 32'd3, 32'd0, 1'b0, acc);
`else
    send(5'd18, 32'd1000, 32'd3, 32'd0, 1'b0, acc);
`endif
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midop_reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midop_reset_result", {32'd0, aluResult}, 64'd0);
    chk("midop_reset_zero", {63'd0, zero}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 1'b0, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
